// File: rtl/axi_lite_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_pkg : AXI-Lite widths, response codes and byte-merge helper |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package axi_lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  function automatic logic [AXI_DATA_W-1:0] apply_wstrb(
    input logic [AXI_DATA_W-1:0] old_val,
    input logic [AXI_DATA_W-1:0] new_val,
    input logic [AXI_STRB_W-1:0] strb
  );
    logic [AXI_DATA_W-1:0] merged;
    merged = old_val;
    for (int b = 0; b < AXI_STRB_W; b++) begin
      if (strb[b]) begin
        merged[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_regs_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_regs_if : AXI-Lite five-channel bundle with modports        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface axi_lite_regs_if;
  import axi_lite_pkg::*;

  logic [AXI_ADDR_W-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [AXI_DATA_W-1:0] wdata;
  logic [AXI_STRB_W-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  resp_t                 bresp;
  logic                  bvalid;
  logic                  bready;

  logic [AXI_ADDR_W-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [AXI_DATA_W-1:0] rdata;
  resp_t                 rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface
`default_nettype wire

// File: rtl/axi_lite_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_regs : AXI-Lite slave with NUM_REGS 32-bit registers,       |
// |                 register 0 is a read-only ID. Rev 1.0                |
// +----------------------------------------------------------------------+
module axi_lite_regs
  import axi_lite_pkg::*;
#(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axi_lite_regs_if.slave         s_axi,
  output logic [NUM_REGS*32-1:0] regs_o,
  output logic [NUM_REGS-1:0]    wr_pulse_o
);

  localparam int                    IDX_W      = $clog2(NUM_REGS);
  localparam logic [AXI_ADDR_W-1:0] ADDR_LIMIT = AXI_ADDR_W'(NUM_REGS * 4);

  logic                  aw_held_q, aw_held_d;
  logic [IDX_W-1:0]      aw_idx_q,  aw_idx_d;
  logic                  aw_ok_q,   aw_ok_d;
  logic                  w_held_q,  w_held_d;
  logic [AXI_DATA_W-1:0] wdata_q,   wdata_d;
  logic [AXI_STRB_W-1:0] wstrb_q,   wstrb_d;
  logic                  bvalid_q,  bvalid_d;
  resp_t                 bresp_q,   bresp_d;
  logic                  rvalid_q,  rvalid_d;
  logic [AXI_DATA_W-1:0] rdata_q,   rdata_d;
  resp_t                 rresp_q,   rresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [AXI_DATA_W-1:0] regs_q [NUM_REGS];
  logic [AXI_DATA_W-1:0] regs_d [NUM_REGS];

  logic             aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0] rd_idx;
  logic             unused_prot;

  assign aw_hs  = s_axi.awvalid && !aw_held_q;
  assign w_hs   = s_axi.wvalid  && !w_held_q;
  assign ar_hs  = s_axi.arvalid && !rvalid_q;
  // A pending B response blocks the commit, so the holds backpressure AW/W.
  assign commit = aw_held_q && w_held_q && !bvalid_q;
  assign rd_idx = s_axi.araddr[IDX_W+1:2];

  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

  always_comb begin
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    aw_ok_d    = aw_ok_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi.awaddr[IDX_W+1:2];
      aw_ok_d   = (s_axi.awaddr < ADDR_LIMIT) && (s_axi.awaddr[IDX_W+1:2] != '0);
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.wdata;
      wstrb_d  = s_axi.wstrb;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
      if (aw_ok_q) begin
        wr_pulse_d[aw_idx_q] = 1'b1;
        regs_d[aw_idx_q]     = apply_wstrb(regs_q[aw_idx_q], wdata_q, wstrb_q);
      end
    end else if (bvalid_q && s_axi.bready) begin
      bvalid_d = 1'b0;
    end
  end

  // Reads sample regs_q directly, so a same-edge commit is not yet visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (s_axi.araddr >= ADDR_LIMIT) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else if (rd_idx == '0) begin
        rdata_d = ID_VALUE;
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = regs_q[rd_idx];
        rresp_d = RESP_OKAY;
      end
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      aw_ok_q    <= 1'b0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      aw_ok_q    <= aw_ok_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  assign s_axi.awready = !aw_held_q;
  assign s_axi.wready  = !w_held_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = !rvalid_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign wr_pulse_o    = wr_pulse_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_o
    if (i == 0) begin : g_id
      assign regs_o[31:0] = ID_VALUE;
    end else begin : g_rw
      assign regs_o[32*i +: 32] = regs_q[i];
    end
  end

endmodule
`default_nettype wire
